// File: rtl/emu_replay_ctrl.sv
// Checkpoint-replay controller: streams a saved image into the FF and MEM chains, then gates the emulated clock.
// Optional trigger output for waveform-dump start is enabled by defining EMU_REPLAY_TRIGGER_EN.
module emu_replay_ctrl #(
    parameter int LOAD_WIDTH  = 64,
    parameter int FF_WORDS    = 16,
    parameter int MEM_WORDS   = 32,
    parameter int CYCLE_WIDTH = 64,
    localparam int MAXW = (FF_WORDS > MEM_WORDS) ? FF_WORDS : MEM_WORDS,
    localparam int AW   = $clog2((MAXW > 2) ? MAXW : 2),
    localparam int IW   = $clog2(FF_WORDS + MEM_WORDS + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [CYCLE_WIDTH-1:0] cfg_start_cycle,
    input  logic [CYCLE_WIDTH-1:0] cfg_run_cycle,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [LOAD_WIDTH-1:0]  ld_data,
    output logic                   chain_wen,
    output logic                   chain_is_mem,
    output logic [AW-1:0]          chain_addr,
    output logic [LOAD_WIDTH-1:0]  chain_wdata,
    input  logic                   stop_req,
    output logic                   emu_clk_en,
    output logic [CYCLE_WIDTH-1:0] cycle,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted
`ifdef EMU_REPLAY_TRIGGER_EN
    ,
    input  logic [CYCLE_WIDTH-1:0] trig_cycle,
    output logic                   trig
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q;
    logic [CYCLE_WIDTH-1:0] rem_q;
    logic [CYCLE_WIDTH-1:0] cycle_q;
    logic                   abort_q;
    logic                   cfg_accept;
    logic                   last_word;

    assign cfg_accept   = cfg_valid & cfg_ready;
    assign last_word    = (idx_q == IW'(FF_WORDS + MEM_WORDS - 1));
    assign chain_wen    = ld_valid & ld_ready;
    assign chain_wdata  = ld_data;
    assign chain_is_mem = (idx_q >= IW'(FF_WORDS));
    // MEM offset computed modulo 2^AW; the true offset always fits in AW bits.
    assign chain_addr   = chain_is_mem ? (idx_q[AW-1:0] - AW'(FF_WORDS)) : idx_q[AW-1:0];
    assign cycle        = cycle_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cfg_ready  = 1'b0;
        ld_ready   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        aborted    = 1'b0;
        emu_clk_en = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                busy      = 1'b0;
                if (cfg_valid) state_d = LOAD;
            end
            LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid && last_word) state_d = SETTLE;
            end
            SETTLE: begin
                state_d = (rem_q == '0) ? DONE : RUN;
            end
            RUN: begin
                emu_clk_en = ~stop_req;
                // The enabled cycle that consumes the last remaining count ends the run.
                if (stop_req || rem_q == CYCLE_WIDTH'(1)) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                aborted = abort_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q   <= '0;
            rem_q   <= '0;
            cycle_q <= '0;
            abort_q <= 1'b0;
        end else begin
            if (cfg_accept) begin
                idx_q   <= '0;
                rem_q   <= cfg_run_cycle;
                cycle_q <= cfg_start_cycle;
                abort_q <= 1'b0;
            end
            if (chain_wen) idx_q <= idx_q + IW'(1);
            if (emu_clk_en) begin
                cycle_q <= cycle_q + CYCLE_WIDTH'(1);
                rem_q   <= rem_q - CYCLE_WIDTH'(1);
            end
            if (state_q == RUN && stop_req) abort_q <= 1'b1;
        end
    end

`ifdef EMU_REPLAY_TRIGGER_EN
    // Compare against the pre-increment cycle of each enabled RUN cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trig <= 1'b0;
        end else begin
            trig <= emu_clk_en && (cycle_q == trig_cycle);
        end
    end
`endif

endmodule

// File: tb/tb_emu_replay_ctrl.sv
// Self-checking bench for emu_replay_ctrl with FF_WORDS=2, MEM_WORDS=3, CYCLE_WIDTH=64.
// Define EMU_REPLAY_TRIGGER_EN for both files to also check the trigger pulse.
module tb_emu_replay_ctrl;

    localparam int LW    = 64;
    localparam int FF    = 2;
    localparam int MEM   = 3;
    localparam int CW    = 64;
    localparam int TOTAL = FF + MEM;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] cfg_start_cycle;
    logic [CW-1:0] cfg_run_cycle;
    logic          ld_valid;
    logic          ld_ready;
    logic [LW-1:0] ld_data;
    logic          chain_wen;
    logic          chain_is_mem;
    logic [1:0]    chain_addr;
    logic [LW-1:0] chain_wdata;
    logic          stop_req;
    logic          emu_clk_en;
    logic [CW-1:0] cycle;
    logic          busy;
    logic          done;
    logic          aborted;
`ifdef EMU_REPLAY_TRIGGER_EN
    logic [CW-1:0] trig_cycle;
    logic          trig;
`endif

    int checks   = 0;
    int failures = 0;

    emu_replay_ctrl #(
        .LOAD_WIDTH (LW),
        .FF_WORDS   (FF),
        .MEM_WORDS  (MEM),
        .CYCLE_WIDTH(CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_start_cycle(cfg_start_cycle),
        .cfg_run_cycle  (cfg_run_cycle),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_data        (ld_data),
        .chain_wen      (chain_wen),
        .chain_is_mem   (chain_is_mem),
        .chain_addr     (chain_addr),
        .chain_wdata    (chain_wdata),
        .stop_req       (stop_req),
        .emu_clk_en     (emu_clk_en),
        .cycle          (cycle),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted)
`ifdef EMU_REPLAY_TRIGGER_EN
        ,
        .trig_cycle     (trig_cycle),
        .trig           (trig)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: word k lands in FF[k] for k<FF, else MEM[k-FF]; a run yields min(run, stop_at-1) enables.
    task automatic run_case(input logic [63:0] start, input logic [63:0] run, input int stall_mode,
                            input int stop_at, input logic [63:0] data_base, input bit noise);
        int            k, guard, rcycles, en, trig_cnt;
        bit            v, stp, abort_exp;
        logic [63:0]   wd, exp_cycle, exp_en, exp_rc, tc;
        trig_cnt = 0;
        tc = start + 64'd2;
        @(negedge clk);
        check("idle_cfg_ready", cfg_ready, 1);
        check("idle_busy", busy, 0);
        cfg_valid = 1'b1;
        cfg_start_cycle = start;
        cfg_run_cycle = run;
`ifdef EMU_REPLAY_TRIGGER_EN
        trig_cycle = tc;
`endif
        @(negedge clk);
        cfg_valid = 1'b0;
        k = 0;
        guard = 0;
        while (k < TOTAL && guard < 100) begin
            case (stall_mode)
                0:       v = 1'b1;
                1:       v = (guard % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            wd = (data_base != 0) ? data_base + 64'(k) : {$urandom, $urandom};
            ld_valid = v;
            ld_data = wd;
            if (noise) begin
                stop_req = 1'($urandom_range(0, 1));
                cfg_valid = 1'($urandom_range(0, 1));
                cfg_start_cycle = {$urandom, $urandom};
                cfg_run_cycle = 64'($urandom_range(0, 3));
            end
            #1;
            check("load_busy", busy, 1);
            check("load_ld_ready", ld_ready, 1);
            check("load_cfg_ready", cfg_ready, 0);
            check("load_wen", chain_wen, v);
            check("load_clk_en", emu_clk_en, 0);
            if (v) begin
                check("load_is_mem", chain_is_mem, (k >= FF));
                check("load_addr", chain_addr, (k < FF) ? 64'(k) : 64'(k - FF));
                check("load_wdata", chain_wdata, wd);
            end
            @(negedge clk);
            if (v) k++;
            guard++;
        end
        if (k < TOTAL) check("load_timeout", 64'(k), 64'(TOTAL));
        ld_valid = 1'b0;
        cfg_valid = 1'b0;
        stop_req = noise;
        #1;
        check("settle_clk_en", emu_clk_en, 0);
        check("settle_ld_ready", ld_ready, 0);
        check("settle_wen", chain_wen, 0);
        check("settle_done", done, 0);
        check("settle_busy", busy, 1);
        stop_req = 1'b0;
        @(negedge clk);
        exp_cycle = start;
        rcycles = 0;
        en = 0;
        guard = 0;
        while (!done && guard < 40) begin
            stp = (stop_at != 0 && rcycles + 1 == stop_at);
            stop_req = stp;
            #1;
`ifdef EMU_REPLAY_TRIGGER_EN
            if (trig) trig_cnt++;
`endif
            check("run_cycle", cycle, exp_cycle);
            check("run_clk_en", emu_clk_en, !stp);
            check("run_busy", busy, 1);
            if (!stp) begin
                exp_cycle = exp_cycle + 64'd1;
                en++;
            end
            rcycles++;
            @(negedge clk);
            stop_req = 1'b0;
            guard++;
        end
`ifdef EMU_REPLAY_TRIGGER_EN
        if (trig) trig_cnt++;
`endif
        abort_exp = (stop_at != 0) && (64'(stop_at) <= run);
        exp_en = abort_exp ? 64'(stop_at - 1) : run;
        exp_rc = abort_exp ? 64'(stop_at) : run;
        check("done_pulse", done, 1);
        check("done_aborted", aborted, abort_exp);
        check("done_cycle", cycle, start + exp_en);
        check("done_enables", 64'(en), exp_en);
        check("done_run_cycles", 64'(rcycles), exp_rc);
        check("done_clk_en", emu_clk_en, 0);
`ifdef EMU_REPLAY_TRIGGER_EN
        check("trig_pulses", 64'(trig_cnt), (exp_en > 64'd2) ? 64'd1 : 64'd0);
`endif
        @(negedge clk);
        check("post_done", done, 0);
        check("post_cfg_ready", cfg_ready, 1);
        check("post_busy", busy, 0);
        check("post_cycle_hold", cycle, start + exp_en);
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_valid = 1'b0;
        cfg_start_cycle = '0;
        cfg_run_cycle = '0;
        ld_valid = 1'b1;
        ld_data = '0;
        stop_req = 1'b0;
`ifdef EMU_REPLAY_TRIGGER_EN
        trig_cycle = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_cycle", cycle, 0);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_wen", chain_wen, 0);
        check("rst_clk_en", emu_clk_en, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        ld_valid = 1'b0;
        rst_n = 1'b1;

        // Back-to-back load, 4 enabled cycles from 100.
        run_case(64'd100, 64'd4, 0, 0, 64'hA, 1'b0);
        // Stalled load toggling ld_valid.
        run_case(64'd100, 64'd4, 1, 0, 64'hA, 1'b0);
        // Zero-length run.
        run_case(64'd55, 64'd0, 0, 0, 64'h0, 1'b0);
        // Cycle counter wrap.
        run_case(64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 0, 0, 64'h0, 1'b0);
        // Abort on the second RUN cycle.
        run_case(64'd700, 64'd10, 0, 2, 64'h0, 1'b0);

        // Reset mid-load on word 3, then a fresh configuration.
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_start_cycle = 64'd500;
        cfg_run_cycle = 64'd2;
        @(negedge clk);
        cfg_valid = 1'b0;
        ld_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("mid_is_mem", chain_is_mem, 1);
        check("mid_addr", chain_addr, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_cfg_ready", cfg_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cycle", cycle, 0);
        check("mid_rst_wen", chain_wen, 0);
        rst_n = 1'b1;
        ld_valid = 1'b0;
        run_case(64'd20, 64'd2, 0, 0, 64'h0, 1'b0);

        // Randomised runs with stalls, aborts and ignored stop/cfg noise during load.
        for (int i = 0; i < 8; i++) begin
            run_case({$urandom, $urandom}, 64'($urandom_range(0, 8)), 2,
                     int'($urandom_range(0, 9)), 64'h0, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
